// File: rtl/lsu_dcache_arb_pkg.sv
// Shared types for the LSU-to-dcache request arbiter and its response tracking queue.
package lsu_dcache_arb_pkg;

  localparam int unsigned NPORT_MAX = 4;
  localparam int unsigned LANE_ID_W = (NPORT_MAX > 1) ? $clog2(NPORT_MAX) : 1;

  typedef logic [LANE_ID_W-1:0] lane_id_t;

  typedef struct packed {
    lane_id_t id0;
    lane_id_t id1;
    logic     v1;
    logic     epoch;
    logic     stale;
  } arb_entry_t;

endpackage

// File: rtl/lsu_dcache_arb_if.sv
// Two-slot dcache request/response port; master is the arbiter, slave is the dcache.
interface lsu_dcache_arb_if #(
  parameter int unsigned TAG_W = 20,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned OFS_W = 4
);
  logic             p0_valid;
  logic             p1_valid;
  logic             op;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] index;
  logic [OFS_W-1:0] p0_offset;
  logic [OFS_W-1:0] p1_offset;
  logic [3:0]       p0_wstrb;
  logic [3:0]       p1_wstrb;
  logic [31:0]      p0_wdata;
  logic [31:0]      p1_wdata;
  logic [1:0]       p0_size;
  logic [1:0]       p1_size;
  logic             uncached;
  logic             addr_ok;
  logic             data_ok;
  logic [31:0]      p0_rdata;
  logic [31:0]      p1_rdata;

  modport master (
    output p0_valid, p1_valid, op, tag, index, p0_offset, p1_offset, p0_wstrb, p1_wstrb,
           p0_wdata, p1_wdata, p0_size, p1_size, uncached,
    input  addr_ok, data_ok, p0_rdata, p1_rdata
  );

  modport slave (
    input  p0_valid, p1_valid, op, tag, index, p0_offset, p1_offset, p0_wstrb, p1_wstrb,
           p0_wdata, p1_wdata, p0_size, p1_size, uncached,
    output addr_ok, data_ok, p0_rdata, p1_rdata
  );
endinterface

// File: rtl/arb_track_fifo.sv
// Circular queue of outstanding dcache transactions with a bulk mark-stale input.
module arb_track_fifo
  import lsu_dcache_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             mark_stale,
  input  arb_entry_t       push_entry,
  output arb_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  arb_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0] stale_q, stale_d;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Stale lives outside the entry storage so a cancel can flag every slot at once.
  always_comb begin
    head       = mem_q[rd_q];
    head.stale = stale_q[rd_q];
    stale_d    = mark_stale ? '1 : stale_q;
    if (push_en) stale_d[wr_q] = push_entry.stale;
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      stale_q <= '0;
    end else begin
      stale_q <= stale_d;
      if (push_en) wr_q <= wr_q + PTR_W'(1);
      if (pop_en)  rd_q <= rd_q + PTR_W'(1);
      if (push_en && !pop_en)      count_q <= count_q + CNT_W'(1);
      else if (pop_en && !push_en) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/lsu_dcache_arb.sv
// Packs in-order LSU lanes onto the two-slot dcache port and routes responses back by lane.
module lsu_dcache_arb
  import lsu_dcache_arb_pkg::*;
#(
  parameter int unsigned NPORT = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned OFS_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      lane_req,
  input  logic [NPORT-1:0][31:0] lane_pa,
  input  logic [NPORT-1:0]      lane_uncached,
  input  logic [NPORT-1:0]      lane_we,
  input  logic [NPORT-1:0][1:0] lane_size,
  input  logic [NPORT-1:0][3:0] lane_wstrb,
  input  logic [NPORT-1:0][31:0] lane_wdata,
  input  logic                  cancel,
  output logic [NPORT-1:0]      lane_addr_ok,
  output logic [NPORT-1:0]      lane_data_ok,
  output logic [NPORT-1:0][31:0] lane_rdata,
  lsu_dcache_arb_if.master      dcache
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             found0, found1, pair, issue_ok, accept, pop, deliver, epoch_q;
  lane_id_t         l0, l1;
  logic [31:0]      pa0, pa1, wdata0, wdata1;
  logic             unc0, unc1, we0, we1;
  logic [1:0]       size0, size1;
  logic [3:0]       wstrb0, wstrb1;
  arb_entry_t       push_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // L0/L1 are the two lowest asserted lanes, i.e. the two oldest in program order.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    l0     = '0;
    l1     = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (lane_req[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          l0     = LANE_ID_W'(i);
        end else if (!found1) begin
          found1 = 1'b1;
          l1     = LANE_ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    pa0 = '0; unc0 = 1'b0; we0 = 1'b0; size0 = '0; wstrb0 = '0; wdata0 = '0;
    pa1 = '0; unc1 = 1'b0; we1 = 1'b0; size1 = '0; wstrb1 = '0; wdata1 = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (l0 == LANE_ID_W'(i)) begin
        pa0 = lane_pa[i]; unc0 = lane_uncached[i]; we0 = lane_we[i];
        size0 = lane_size[i]; wstrb0 = lane_wstrb[i]; wdata0 = lane_wdata[i];
      end
      if (l1 == LANE_ID_W'(i)) begin
        pa1 = lane_pa[i]; unc1 = lane_uncached[i]; we1 = lane_we[i];
        size1 = lane_size[i]; wstrb1 = lane_wstrb[i]; wdata1 = lane_wdata[i];
      end
    end
  end

  assign pair = found1 && !unc0 && !unc1 && (we0 == we1) &&
                (pa0[OFS_W +: TAG_W + IDX_W] == pa1[OFS_W +: TAG_W + IDX_W]);
  // Uncached accesses wait until every earlier transaction has drained.
  assign issue_ok = found0 && !reset && !cancel && !fifo_full &&
                    !(unc0 && (fifo_count != '0));
  assign accept   = issue_ok && dcache.addr_ok;

  assign dcache.p0_valid  = issue_ok;
  assign dcache.p1_valid  = issue_ok && pair;
  assign dcache.op        = we0;
  assign dcache.uncached  = unc0;
  assign dcache.tag       = pa0[OFS_W + IDX_W +: TAG_W];
  assign dcache.index     = pa0[OFS_W +: IDX_W];
  assign dcache.p0_offset = pa0[OFS_W-1:0];
  assign dcache.p1_offset = pa1[OFS_W-1:0];
  assign dcache.p0_wstrb  = wstrb0;
  assign dcache.p1_wstrb  = wstrb1;
  assign dcache.p0_wdata  = wdata0;
  assign dcache.p1_wdata  = wdata1;
  assign dcache.p0_size   = size0;
  assign dcache.p1_size   = size1;

  assign push_entry = '{id0: l0, id1: l1, v1: pair, epoch: epoch_q, stale: 1'b0};
  assign pop        = dcache.data_ok && !fifo_empty && !reset;
  assign deliver    = pop && !head.stale && (head.epoch == epoch_q);

  always_comb begin
    lane_addr_ok = '0;
    lane_data_ok = '0;
    lane_rdata   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (accept && l0 == LANE_ID_W'(i)) lane_addr_ok[i] = 1'b1;
      if (accept && pair && l1 == LANE_ID_W'(i)) lane_addr_ok[i] = 1'b1;
      if (deliver && head.id0 == LANE_ID_W'(i)) begin
        lane_data_ok[i] = 1'b1;
        lane_rdata[i]   = dcache.p0_rdata;
      end
      if (deliver && head.v1 && head.id1 == LANE_ID_W'(i)) begin
        lane_data_ok[i] = 1'b1;
        lane_rdata[i]   = dcache.p1_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       epoch_q <= 1'b0;
    else if (cancel) epoch_q <= ~epoch_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dcache.data_ok && fifo_empty))
        else $error("dcache_data_ok with no outstanding transaction");
    end
  end

  arb_track_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .pop        (pop),
    .mark_stale (cancel && !reset),
    .push_entry (push_entry),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// Directed bench for lsu_dcache_arb with four lanes and a four-deep tracking queue.
module tb_lsu_dcache_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req, unc, we, aok, dok;
  logic [3:0][31:0] pa, wdata, rdata;
  logic [3:0][1:0]  size;
  logic [3:0][3:0]  wstrb;
  logic             cancel;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  lsu_dcache_arb_if #(.TAG_W(20), .IDX_W(8), .OFS_W(4)) dc ();

  lsu_dcache_arb #(
    .NPORT(4), .DEPTH(4), .TAG_W(20), .IDX_W(8), .OFS_W(4)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .lane_req      (req),
    .lane_pa       (pa),
    .lane_uncached (unc),
    .lane_we       (we),
    .lane_size     (size),
    .lane_wstrb    (wstrb),
    .lane_wdata    (wdata),
    .cancel        (cancel),
    .lane_addr_ok  (aok),
    .lane_data_ok  (dok),
    .lane_rdata    (rdata),
    .dcache        (dc.master)
  );

  task automatic idle();
    req = '0; unc = '0; we = '0; pa = '0; size = '0; wstrb = '0; wdata = '0;
    cancel = 1'b0;
    dc.addr_ok = 1'b1; dc.data_ok = 1'b0; dc.p0_rdata = '0; dc.p1_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst = 1'b1; req = 4'b0001; dc.data_ok = 1'b1; #1;
    checks++;
    if (dc.p0_valid !== 1'b0 || dc.p1_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b%b exp=00", dc.p0_valid, dc.p1_valid);
    end
    checks++;
    if (aok !== 4'b0000 || dok !== 4'b0000) begin
      failures++; $display("FAIL reset_ok got aok=%b dok=%b exp=0000/0000", aok, dok);
    end
    @(negedge clk); idle(); rst = 1'b0;
  endtask

  task automatic test_pair();
    @(negedge clk); idle(); req = 4'b0011; pa[0] = 32'h1000; pa[1] = 32'h1004;
    dc.addr_ok = 1'b0; #1;
    checks++;
    if (dc.p1_valid !== 1'b1 || aok !== 4'b0000) begin
      failures++; $display("FAIL pair_stall got p1v=%b aok=%b exp=1/0000", dc.p1_valid, aok);
    end
    @(negedge clk); dc.addr_ok = 1'b1; #1;
    checks++;
    if (aok !== 4'b0011) begin
      failures++; $display("FAIL pair_addr_ok got=%b exp=0011", aok);
    end
    checks++;
    if (dc.tag !== 20'h1 || dc.p0_offset !== 4'h0 || dc.p1_offset !== 4'h4) begin
      failures++;
      $display("FAIL pair_fields got tag=%h o0=%h o1=%h exp=1/0/4", dc.tag, dc.p0_offset,
               dc.p1_offset);
    end
    @(negedge clk); idle(); dc.data_ok = 1'b1; dc.p0_rdata = 32'hAA; dc.p1_rdata = 32'hBB; #1;
    checks++;
    if (dok !== 4'b0011 || rdata[0] !== 32'hAA || rdata[1] !== 32'hBB) begin
      failures++;
      $display("FAIL pair_resp got dok=%b r0=%h r1=%h exp=0011/aa/bb", dok, rdata[0], rdata[1]);
    end
  endtask

  task automatic test_split();
    @(negedge clk); idle(); req = 4'b0011; pa[0] = 32'h1000; pa[1] = 32'h2000; #1;
    checks++;
    if (aok !== 4'b0001 || dc.p1_valid !== 1'b0) begin
      failures++; $display("FAIL split_c0 got aok=%b p1v=%b exp=0001/0", aok, dc.p1_valid);
    end
    @(negedge clk); req = 4'b0010; #1;
    checks++;
    if (aok !== 4'b0010 || dc.tag !== 20'h2) begin
      failures++; $display("FAIL split_c1 got aok=%b tag=%h exp=0010/2", aok, dc.tag);
    end
    @(negedge clk); idle(); dc.data_ok = 1'b1; dc.p0_rdata = 32'h11; #1;
    checks++;
    if (dok !== 4'b0001 || rdata[0] !== 32'h11) begin
      failures++; $display("FAIL split_r0 got dok=%b r0=%h exp=0001/11", dok, rdata[0]);
    end
    @(negedge clk); dc.p0_rdata = 32'h22; #1;
    checks++;
    if (dok !== 4'b0010 || rdata[1] !== 32'h22) begin
      failures++; $display("FAIL split_r1 got dok=%b r1=%h exp=0010/22", dok, rdata[1]);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h100 + 32'(k) * 32'h10; #1;
      checks++;
      if (aok !== 4'b0001) begin
        failures++; $display("FAIL full_fill%0d got aok=%b exp=0001", k, aok);
      end
    end
    @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h500;
    dc.data_ok = 1'b1; dc.p0_rdata = 32'h77; #1;
    checks++;
    if (dc.p0_valid !== 1'b0 || aok !== 4'b0000) begin
      failures++; $display("FAIL full_inhibit got p0v=%b aok=%b exp=0/0000", dc.p0_valid, aok);
    end
    checks++;
    if (dok !== 4'b0001 || rdata[0] !== 32'h77) begin
      failures++; $display("FAIL full_pop got dok=%b r0=%h exp=0001/77", dok, rdata[0]);
    end
    @(negedge clk); dc.data_ok = 1'b0; #1;
    checks++;
    if (dc.p0_valid !== 1'b1 || aok !== 4'b0001) begin
      failures++; $display("FAIL full_resume got p0v=%b aok=%b exp=1/0001", dc.p0_valid, aok);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); dc.data_ok = 1'b1; #1;
      checks++;
      if (dok !== 4'b0001) begin
        failures++; $display("FAIL full_drain%0d got dok=%b exp=0001", k, dok);
      end
    end
  endtask

  task automatic test_uncached();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h1000 + 32'(k) * 32'h10; #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); req = 4'b0001; unc = 4'b0001; we = 4'b0001; pa[0] = 32'h8000;
      wstrb[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
      dc.data_ok = (k < 2); dc.p0_rdata = 32'h30 + 32'(k); #1;
      if (k < 2) begin
        checks++;
        if (dc.p0_valid !== 1'b0 || dok !== 4'b0001) begin
          failures++;
          $display("FAIL unc_hold%0d got p0v=%b dok=%b exp=0/0001", k, dc.p0_valid, dok);
        end
      end else begin
        checks++;
        if (dc.p0_valid !== 1'b1 || dc.uncached !== 1'b1 || dc.op !== 1'b1 ||
            dc.p0_wdata !== 32'hDEADBEEF || aok !== 4'b0001) begin
          failures++;
          $display("FAIL unc_issue got p0v=%b unc=%b op=%b wd=%h aok=%b exp=1/1/1/deadbeef/0001",
                   dc.p0_valid, dc.uncached, dc.op, dc.p0_wdata, aok);
        end
      end
    end
    @(negedge clk); idle(); dc.data_ok = 1'b1; #1;
    checks++;
    if (dok !== 4'b0001) begin
      failures++; $display("FAIL unc_resp got dok=%b exp=0001", dok);
    end
  endtask

  task automatic test_cancel();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h1000; #1;
    end
    @(negedge clk); idle(); req = 4'b0001; cancel = 1'b1; #1;
    checks++;
    if (dc.p0_valid !== 1'b0 || aok !== 4'b0000) begin
      failures++; $display("FAIL cancel_issue got p0v=%b aok=%b exp=0/0000", dc.p0_valid, aok);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); dc.data_ok = 1'b1; #1;
      checks++;
      if (dok !== 4'b0000) begin
        failures++; $display("FAIL cancel_drain%0d got dok=%b exp=0000", k, dok);
      end
    end
    @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h1000; #1;
    checks++;
    if (aok !== 4'b0001) begin
      failures++; $display("FAIL cancel_new got aok=%b exp=0001", aok);
    end
    @(negedge clk); idle(); dc.data_ok = 1'b1; dc.p0_rdata = 32'h55; #1;
    checks++;
    if (dok !== 4'b0001 || rdata[0] !== 32'h55) begin
      failures++; $display("FAIL cancel_resp got dok=%b r0=%h exp=0001/55", dok, rdata[0]);
    end
    // Two cancels return the epoch to its old value; the entry must stay dead.
    @(negedge clk); idle(); req = 4'b0001; pa[0] = 32'h1000;
    @(negedge clk); idle(); cancel = 1'b1;
    @(negedge clk); idle(); cancel = 1'b1;
    @(negedge clk); idle(); dc.data_ok = 1'b1; #1;
    checks++;
    if (dok !== 4'b0000) begin
      failures++; $display("FAIL cancel_twice got dok=%b exp=0000", dok);
    end
  endtask

  task automatic test_four_lanes();
    @(negedge clk); idle(); req = 4'b1111;
    pa[0] = 32'h1000; pa[1] = 32'h2000; pa[2] = 32'h3000; pa[3] = 32'h3008; #1;
    checks++;
    if (aok !== 4'b0001 || dc.p1_valid !== 1'b0) begin
      failures++; $display("FAIL four_c0 got aok=%b p1v=%b exp=0001/0", aok, dc.p1_valid);
    end
    @(negedge clk); req = 4'b1110; #1;
    checks++;
    if (aok !== 4'b0010) begin
      failures++; $display("FAIL four_c1 got aok=%b exp=0010", aok);
    end
    @(negedge clk); req = 4'b1100; rst = 1'b1; #1;
    checks++;
    if (aok !== 4'b0000 || dc.p0_valid !== 1'b0 || dok !== 4'b0000) begin
      failures++;
      $display("FAIL four_reset got aok=%b p0v=%b dok=%b exp=0000/0/0000", aok, dc.p0_valid, dok);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (aok !== 4'b1100 || dc.p1_valid !== 1'b1 || dc.tag !== 20'h3 ||
        dc.p1_offset !== 4'h8) begin
      failures++;
      $display("FAIL four_pair got aok=%b p1v=%b tag=%h o1=%h exp=1100/1/3/8", aok, dc.p1_valid,
               dc.tag, dc.p1_offset);
    end
    @(negedge clk); idle(); dc.data_ok = 1'b1; dc.p0_rdata = 32'hC2; dc.p1_rdata = 32'hC3; #1;
    checks++;
    if (dok !== 4'b1100 || rdata[2] !== 32'hC2 || rdata[3] !== 32'hC3) begin
      failures++;
      $display("FAIL four_resp got dok=%b r2=%h r3=%h exp=1100/c2/c3", dok, rdata[2], rdata[3]);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_pair();
    test_split();
    test_full();
    test_uncached();
    test_cancel();
    test_four_lanes();
    @(negedge clk); idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
